serial_parity_engine: RTL and testbench

Parametrised serial parity generator/checker, the successor to the fixed 32-bit serial parity generator. It accepts a bit stream under a valid qualifier and groups it into frames of `FRAME_LEN` data bits, with even or odd parity. In generate mode it reports the frame parity. In check mode it also consumes one trailing parity bit and flags a mismatch. It sits between the serial peripheral front-ends and the status/interrupt logic.

---
 rtl/serial_parity_engine.sv | 110 +++++++++++
 tb/tb_serial_parity_engine.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_parity_engine.sv
// Serial parity generator/checker: groups accepted bits into FRAME_LEN-bit frames,
// reports even/odd frame parity and, in check mode, compares a trailing parity bit.
module serial_parity_engine #(
  parameter int unsigned FRAME_LEN = 32,
  parameter bit          ODD       = 1'b0,
  parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             ip_valid,
  input  logic             ip,
  input  logic             abort,
  output logic             parity,
  output logic             frame_done,
  output logic             parity_err,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PBIT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e           state_q, state_d;
  logic             mode_q, mode_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= 1'b0;
      parity_q <= ODD;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      parity_q <= parity_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; abort outranks any bit presented in the same cycle
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    parity_d = parity_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if (abort) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      parity_d = ODD;
    end else if (ip_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          mode_d   = mode;
          parity_d = ODD ^ ip;
          cnt_d    = CNT_W'(1);
          state_d  = ST_DATA;
        end
        ST_DATA: begin
          parity_d = parity_q ^ ip;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            if (mode_q) begin
              state_d = ST_PBIT;
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_PBIT: begin
          // Received parity bit is compared, never folded into the running parity
          err_d   = (ip != parity_q);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign parity     = parity_q;
  assign frame_done = done_q;
  assign parity_err = err_q;
  assign busy       = busy_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_serial_parity_engine.sv
// Self-checking bench: three engine configurations share one random stream and are
// compared every cycle against a frame-level reference model.
module tb_serial_parity_engine;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mode = 1'b0, ip_valid = 1'b0, ip = 1'b0, abort = 1'b0;
  logic [2:0] par, done, err, busy;
  logic [3:0] cnt_e8, cnt_o8;
  logic [5:0] cnt_e32;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  serial_parity_engine #(.FRAME_LEN(8), .ODD(1'b0)) u_e8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ip_valid(ip_valid), .ip(ip), .abort(abort),
    .parity(par[0]), .frame_done(done[0]), .parity_err(err[0]), .busy(busy[0]), .bit_cnt(cnt_e8));
  serial_parity_engine #(.FRAME_LEN(8), .ODD(1'b1)) u_o8 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ip_valid(ip_valid), .ip(ip), .abort(abort),
    .parity(par[1]), .frame_done(done[1]), .parity_err(err[1]), .busy(busy[1]), .bit_cnt(cnt_o8));
  serial_parity_engine #(.FRAME_LEN(32), .ODD(1'b0)) u_e32 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .ip_valid(ip_valid), .ip(ip), .abort(abort),
    .parity(par[2]), .frame_done(done[2]), .parity_err(err[2]), .busy(busy[2]), .bit_cnt(cnt_e32));

  // Reference model: the data bits of the current frame plus frame-level flags
  int    len_m [NI] = '{8, 8, 32};
  bit    odd_m [NI] = '{1'b0, 1'b1, 1'b0};
  string nm    [NI] = '{"e8", "o8", "e32"};
  bit    fbits [NI][32];
  int    nb    [NI];
  bit    fmode [NI];
  bit    idle_m[NI];
  bit    par_m [NI];
  bit    done_m[NI];
  bit    err_m [NI];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit frame_parity(input int k);
    bit r = odd_m[k];
    for (int i = 0; i < nb[k]; i++) r ^= fbits[k][i];
    return r;
  endfunction

  function automatic int cnt_of(input int k);
    case (k)
      0:       return int'(cnt_e8);
      1:       return int'(cnt_o8);
      default: return int'(cnt_e32);
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      nb[k] = 0; idle_m[k] = 1'b1; par_m[k] = odd_m[k];
      done_m[k] = 1'b0; err_m[k] = 1'b0; fmode[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit v, input bit b, input bit m, input bit a);
    for (int k = 0; k < NI; k++) begin
      done_m[k] = 1'b0;
      err_m[k]  = 1'b0;
      if (a) begin
        nb[k] = 0; idle_m[k] = 1'b1; par_m[k] = odd_m[k];
      end else if (v) begin
        if (idle_m[k]) begin
          nb[k] = 1; fbits[k][0] = b; fmode[k] = m; idle_m[k] = 1'b0;
          par_m[k] = frame_parity(k);
        end else if (nb[k] < len_m[k]) begin
          fbits[k][nb[k]] = b;
          nb[k]++;
          par_m[k] = frame_parity(k);
          if (nb[k] == len_m[k] && !fmode[k]) begin
            done_m[k] = 1'b1; idle_m[k] = 1'b1;
          end
        end else begin
          err_m[k] = (b != par_m[k]); done_m[k] = 1'b1; idle_m[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      check({nm[k], ".parity"},     int'(par[k]),  int'(par_m[k]));
      check({nm[k], ".frame_done"}, int'(done[k]), int'(done_m[k]));
      check({nm[k], ".parity_err"}, int'(err[k]),  int'(err_m[k]));
      check({nm[k], ".busy"},       int'(busy[k]), int'(!idle_m[k]));
      check({nm[k], ".bit_cnt"},    cnt_of(k),     nb[k]);
    end
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare
  task automatic cycle(input bit v, input bit b, input bit m, input bit a);
    ip_valid = v; ip = b; mode = m; abort = a;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(v, b, m, a);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("rst.e32_cnt", int'(cnt_e32), 0);
    check("rst.e32_busy", int'(busy[2]), 0);
    check("rst.o8_parity", int'(par[1]), 1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0]  pat;
    bit          x;
    bit          b;
    int          d_idx[$];

    model_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b1;

    // Even/odd generate on 10110010
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) cycle(1'b1, pat[i], 1'b0, 1'b0);
    check("gen8.done_even", int'(done[0]), 1);
    check("gen8.done_odd", int'(done[1]), 1);
    check("gen8.par_even", int'(par[0]), 0);
    check("gen8.par_odd", int'(par[1]), 1);
    check("gen8.err", int'(err[0]), 0);
    check("gen8.cnt", int'(cnt_e8), 8);

    // Check mode with valid gaps; good then bad parity bit
    pat = 8'b1110_0000;
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 7; i >= 0; i--) begin
        repeat ($urandom_range(0, 2)) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, pat[i], 1'b1, 1'b0);
      end
      check("chk8.no_early_done", int'(done[0]), 0);
      check("chk8.busy_in_pbit", int'(busy[0]), 1);
      check("chk8.cnt_in_pbit", int'(cnt_e8), 8);
      repeat ($urandom_range(1, 3)) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, (f == 0), 1'b1, 1'b0);
      check("chk8.done", int'(done[0]), 1);
      check("chk8.err", int'(err[0]), (f == 0) ? 0 : 1);
    end

    // Abort after 17 bits with a valid bit in the same cycle, then a fresh frame
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check("abort.cnt", int'(cnt_e32), 0);
    check("abort.parity", int'(par[2]), 0);
    check("abort.busy", int'(busy[2]), 0);
    check("abort.no_done", int'(done[2]), 0);
    x = 1'b0;
    for (int i = 0; i < 32; i++) begin
      b = 1'($urandom_range(0, 1));
      x ^= b;
      cycle(1'b1, b, 1'b0, 1'b0);
    end
    check("abort.fresh_done", int'(done[2]), 1);
    check("abort.fresh_parity", int'(par[2]), int'(x));

    // Asynchronous reset with five bits in flight
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check("rst.cnt_before", int'(cnt_e32), 5);
    async_reset();

    // Back-to-back frames of all ones
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (done[2]) begin
        d_idx.push_back(i);
        check("b2b.parity", int'(par[2]), 0);
      end
    end
    check("b2b.pulses", d_idx.size(), 2);
    if (d_idx.size() == 2) check("b2b.spacing", d_idx[1] - d_idx[0], 32);

    // Mode toggled mid-frame takes effect only on the next frame
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("mode.gen_done", int'(done[0]), 1);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    check("mode.chk_waits", int'(done[0]), 0);
    cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    check("mode.chk_done", int'(done[0]), 1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      cycle(($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
